exc_commit: RTL and testbench

// - Exception/interrupt commit point at the MEM stage, directly upstream of cp0.
// - Prioritises per-instruction exception flags and the pending-interrupt request, kills younger instructions,
//   and drives cp0's exc_* update port with registered outputs.
// - Holds a redirect (exception vector or EPC for eret) toward fetch until fetch accepts it.

---
 rtl/exc_commit.sv | 140 ++++++++++++++
 tb/tb_exc_commit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exc_commit.sv
// rtl/exc_commit.sv - MEM-stage exception/interrupt commit point feeding cp0 and the fetch redirect.
// Optional exception counter built when EXC_CNT_EN is defined.
module exc_commit #(
  parameter logic [31:0] VEC_BEV1 = 32'hBFC00380,
  parameter logic [31:0] VEC_BEV0 = 32'h80000180,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m_valid,
  input  logic             m_stall,
  input  logic [31:0]      m_pc,
  input  logic             m_bd,
  input  logic             m_adel_if,
  input  logic             m_ri,
  input  logic             m_ov,
  input  logic             m_sys,
  input  logic             m_bp,
  input  logic             m_adel_d,
  input  logic             m_ades_d,
  input  logic [31:0]      m_daddr,
  input  logic             m_eret,
  input  logic             int_req,
  input  logic             status_bev,
  input  logic [31:0]      cp0_epc,
  output logic             flush,
  output logic             exc_valid,
  output logic [4:0]       exc_excode,
  output logic             exc_bd,
  output logic [31:0]      exc_epc,
  output logic [31:0]      exc_badvaddr,
  output logic             exc_eret,
  output logic             redir_valid,
  output logic [31:0]      redir_pc,
  input  logic             redir_ready,
  output logic [CNT_W-1:0] exc_cnt
);

  typedef enum logic {IDLE, REDIR} state_t;

  state_t      state;
  logic        any_event;
  logic        take;
  logic [4:0]  sel_code;
  logic [31:0] sel_badvaddr;
  logic        sel_eret;
  logic [31:0] redir_pc_q;

  assign any_event = int_req | m_adel_if | m_ri | m_ov | m_sys | m_bp |
                     m_adel_d | m_ades_d | m_eret;
  assign take  = resetn & (state == IDLE) & m_valid & ~m_stall & any_event;
  assign flush = take;

  // Fixed priority: interrupt first, then fetch-side faults, then data-side faults, eret last.
  always_comb begin
    sel_code     = 5'h00;
    sel_badvaddr = 32'h0;
    sel_eret     = 1'b0;
    if (int_req) begin
      sel_code = 5'h00;
    end else if (m_adel_if) begin
      sel_code     = 5'h04;
      sel_badvaddr = m_pc;
    end else if (m_ri) begin
      sel_code = 5'h0a;
    end else if (m_ov) begin
      sel_code = 5'h0c;
    end else if (m_sys) begin
      sel_code = 5'h08;
    end else if (m_bp) begin
      sel_code = 5'h09;
    end else if (m_adel_d) begin
      sel_code     = 5'h04;
      sel_badvaddr = m_daddr;
    end else if (m_ades_d) begin
      sel_code     = 5'h05;
      sel_badvaddr = m_daddr;
    end else begin
      sel_eret = m_eret;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      exc_valid    <= 1'b0;
      exc_excode   <= 5'h00;
      exc_bd       <= 1'b0;
      exc_epc      <= 32'h0;
      exc_badvaddr <= 32'h0;
      exc_eret     <= 1'b0;
      redir_valid  <= 1'b0;
      redir_pc_q   <= 32'h0;
    end else begin
      exc_valid <= 1'b0;
      exc_eret  <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            state        <= REDIR;
            exc_valid    <= 1'b1;
            exc_excode   <= sel_code;
            exc_bd       <= m_bd;
            exc_epc      <= m_bd ? (m_pc - 32'd4) : m_pc;
            exc_badvaddr <= sel_badvaddr;
            exc_eret     <= sel_eret;
            redir_valid  <= 1'b1;
            redir_pc_q   <= status_bev ? VEC_BEV1 : VEC_BEV0;
          end
        end
        REDIR: begin
          // eret target is latched from EPC during the pulse cycle so it stays stable afterwards.
          if (exc_eret) begin
            redir_pc_q <= cp0_epc;
          end
          if (redir_ready) begin
            state       <= IDLE;
            redir_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign redir_pc = exc_eret ? cp0_epc : redir_pc_q;

`ifdef EXC_CNT_EN
  always_ff @(posedge clk) begin
    if (!resetn) begin
      exc_cnt <= '0;
    end else if (exc_valid && !exc_eret) begin
      exc_cnt <= exc_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`else
  assign exc_cnt = '0;
`endif

endmodule

// File: tb/tb_exc_commit.sv
// tb/tb_exc_commit.sv - self-checking bench for exc_commit with directed cases and a randomized reference model.
module tb_exc_commit;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m_valid, m_stall, m_bd;
  logic [31:0] m_pc, m_daddr, cp0_epc;
  logic        m_adel_if, m_ri, m_ov, m_sys, m_bp, m_adel_d, m_ades_d, m_eret;
  logic        int_req, status_bev, redir_ready;
  logic        flush, exc_valid, exc_bd, exc_eret, redir_valid;
  logic [4:0]  exc_excode;
  logic [31:0] exc_epc, exc_badvaddr, redir_pc;
  logic [31:0] exc_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] exp_cnt;

  localparam logic [31:0] BEV1 = 32'hBFC00380;
  localparam logic [31:0] BEV0 = 32'h80000180;
  localparam logic [4:0]  CODE [0:8] = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h04, 5'h05, 5'h00};

  exc_commit dut (
    .clk(clk), .resetn(resetn), .m_valid(m_valid), .m_stall(m_stall), .m_pc(m_pc), .m_bd(m_bd),
    .m_adel_if(m_adel_if), .m_ri(m_ri), .m_ov(m_ov), .m_sys(m_sys), .m_bp(m_bp),
    .m_adel_d(m_adel_d), .m_ades_d(m_ades_d), .m_daddr(m_daddr), .m_eret(m_eret),
    .int_req(int_req), .status_bev(status_bev), .cp0_epc(cp0_epc), .flush(flush),
    .exc_valid(exc_valid), .exc_excode(exc_excode), .exc_bd(exc_bd), .exc_epc(exc_epc),
    .exc_badvaddr(exc_badvaddr), .exc_eret(exc_eret), .redir_valid(redir_valid),
    .redir_pc(redir_pc), .redir_ready(redir_ready), .exc_cnt(exc_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_ref(input logic [31:0] c);
`ifdef EXC_CNT_EN
    return c;
`else
    return 32'd0;
`endif
  endfunction

  // Index into the priority list of the highest-priority raised event, -1 if none.
  function automatic int winner();
    logic [8:0] f;
    f = {m_eret, m_ades_d, m_adel_d, m_bp, m_sys, m_ov, m_ri, m_adel_if, int_req};
    for (int i = 0; i < 9; i++) if (f[i]) return i;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    m_valid = 0; m_stall = 0; m_pc = 0; m_bd = 0; m_adel_if = 0; m_ri = 0; m_ov = 0;
    m_sys = 0; m_bp = 0; m_adel_d = 0; m_ades_d = 0; m_daddr = 0; m_eret = 0;
    int_req = 0; redir_ready = 0;
  endtask

  task automatic release_redir();
    redir_ready = 1;
    tick();
    redir_ready = 0;
  endtask

  task automatic test_reset();
    resetn = 0; clr(); status_bev = 0; cp0_epc = 0;
    m_valid = 1; m_ri = 1;
    #1;
    tests++; if (flush !== 1'b0) begin fails++; $display("FAIL rst_flush: got %0b want 0", flush); end
    tick(); tick(); clr();
    tests++; if (exc_valid !== 1'b0 || redir_valid !== 1'b0 || exc_eret !== 1'b0 || exc_bd !== 1'b0) begin
      fails++; $display("FAIL rst_flags: valid=%0b redir=%0b eret=%0b bd=%0b want 0", exc_valid, redir_valid, exc_eret, exc_bd); end
    tests++; if (exc_excode !== 5'h0 || exc_epc !== 32'h0 || exc_badvaddr !== 32'h0 || redir_pc !== 32'h0 || exc_cnt !== 32'h0) begin
      fails++; $display("FAIL rst_values: code=%h epc=%h bva=%h rpc=%h cnt=%h want 0", exc_excode, exc_epc, exc_badvaddr, redir_pc, exc_cnt); end
    resetn = 1; exp_cnt = 0;
    tick();
  endtask

  task automatic test_ri();
    clr(); m_valid = 1; m_ri = 1; m_pc = 32'hBFC00100; status_bev = 1;
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL ri_flush: got %0b want 1", flush); end
    tick(); clr();
    tests++; if (exc_valid !== 1'b1 || exc_excode !== 5'h0a || exc_epc !== 32'hBFC00100 || exc_badvaddr !== 32'h0) begin
      fails++; $display("FAIL ri_exc: valid=%0b code=%h epc=%h bva=%h want 1 0a bfc00100 0", exc_valid, exc_excode, exc_epc, exc_badvaddr); end
    tests++; if (redir_valid !== 1'b1 || redir_pc !== BEV1) begin
      fails++; $display("FAIL ri_redir: valid=%0b pc=%h want 1 %h", redir_valid, redir_pc, BEV1); end
    exp_cnt++;
    tick();
    tests++; if (exc_valid !== 1'b0 || exc_cnt !== cnt_ref(exp_cnt)) begin
      fails++; $display("FAIL ri_pulse: valid=%0b cnt=%0d want 0 %0d", exc_valid, exc_cnt, cnt_ref(exp_cnt)); end
    release_redir();
    tests++; if (redir_valid !== 1'b0) begin fails++; $display("FAIL ri_release: redir_valid=%0b want 0", redir_valid); end
  endtask

  task automatic test_ov_bd();
    clr(); m_valid = 1; m_ov = 1; m_bd = 1; m_pc = 32'h80001004; status_bev = 0;
    tick(); clr();
    tests++; if (exc_excode !== 5'h0c || exc_bd !== 1'b1 || exc_epc !== 32'h80001000 || redir_pc !== BEV0) begin
      fails++; $display("FAIL ov_bd: code=%h bd=%0b epc=%h rpc=%h want 0c 1 80001000 %h", exc_excode, exc_bd, exc_epc, redir_pc, BEV0); end
    exp_cnt++;
    release_redir();
  endtask

  task automatic test_int_prio();
    clr(); m_valid = 1; m_ades_d = 1; m_daddr = 32'h80002003; int_req = 1; m_pc = 32'h80000400;
    tick(); clr();
    tests++; if (exc_excode !== 5'h00 || exc_badvaddr !== 32'h0 || exc_epc !== 32'h80000400) begin
      fails++; $display("FAIL int_wins: code=%h bva=%h epc=%h want 00 0 80000400", exc_excode, exc_badvaddr, exc_epc); end
    exp_cnt++;
    release_redir();
    m_valid = 1; m_ades_d = 1; m_daddr = 32'h80002003;
    tick(); clr();
    tests++; if (exc_excode !== 5'h05 || exc_badvaddr !== 32'h80002003) begin
      fails++; $display("FAIL ades: code=%h bva=%h want 05 80002003", exc_excode, exc_badvaddr); end
    exp_cnt++;
    release_redir();
  endtask

  task automatic test_eret();
    clr(); cp0_epc = 32'h80003000; m_valid = 1; m_eret = 1;
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL eret_flush: got %0b want 1", flush); end
    tick(); clr();
    tests++; if (exc_valid !== 1'b1 || exc_eret !== 1'b1 || redir_pc !== 32'h80003000) begin
      fails++; $display("FAIL eret: valid=%0b eret=%0b rpc=%h want 1 1 80003000", exc_valid, exc_eret, redir_pc); end
    tick();
    tests++; if (exc_cnt !== cnt_ref(exp_cnt) || redir_pc !== 32'h80003000) begin
      fails++; $display("FAIL eret_hold: cnt=%0d rpc=%h want %0d 80003000", exc_cnt, redir_pc, cnt_ref(exp_cnt)); end
    release_redir();
  endtask

  task automatic test_redir_hold();
    int held = 0;
    clr(); status_bev = 0; m_valid = 1; m_sys = 1;
    tick(); clr();
    exp_cnt++;
    for (int i = 0; i < 4; i++) begin
      redir_ready = (i == 3); m_valid = 1; m_sys = i[0];
      #1;
      if (redir_valid) held++;
      tests++; if (flush !== 1'b0 || redir_pc !== BEV0) begin
        fails++; $display("FAIL hold_cycle%0d: flush=%0b rpc=%h want 0 %h", i, flush, redir_pc, BEV0); end
      if (i > 0) begin
        tests++; if (exc_valid !== 1'b0) begin fails++; $display("FAIL hold_repulse%0d: exc_valid=%0b want 0", i, exc_valid); end
      end
      tick();
    end
    clr();
    tests++; if (held != 4 || redir_valid !== 1'b0) begin
      fails++; $display("FAIL hold_len: held=%0d redir_valid=%0b want 4 0", held, redir_valid); end
  endtask

  task automatic test_stall_and_reset();
    clr(); m_valid = 1; m_bp = 1; m_stall = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      tests++; if (flush !== 1'b0) begin fails++; $display("FAIL stall_flush%0d: got %0b want 0", i, flush); end
      tick();
      tests++; if (exc_valid !== 1'b0) begin fails++; $display("FAIL stall_valid%0d: got %0b want 0", i, exc_valid); end
    end
    m_stall = 0;
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL unstall_flush: got %0b want 1", flush); end
    tick(); clr();
    tests++; if (exc_valid !== 1'b1 || exc_excode !== 5'h09) begin
      fails++; $display("FAIL unstall_exc: valid=%0b code=%h want 1 09", exc_valid, exc_excode); end
    resetn = 0;
    tick();
    tests++; if (redir_valid !== 1'b0 || exc_valid !== 1'b0 || redir_pc !== 32'h0 || exc_cnt !== 32'h0) begin
      fails++; $display("FAIL redir_reset: redir=%0b valid=%0b rpc=%h cnt=%0d want 0", redir_valid, exc_valid, redir_pc, exc_cnt); end
    resetn = 1; exp_cnt = 0;
    m_valid = 1; m_ri = 1;
    #1;
    tests++; if (flush !== 1'b1) begin fails++; $display("FAIL post_reset_take: flush=%0b want 1", flush); end
    tick(); clr();
    exp_cnt++;
    release_redir();
  endtask

  task automatic test_random();
    logic        model_redir = 0, cap_pend = 0, inc_pend = 0, take, e_eret, e_bd;
    logic [31:0] model_rpc = 0, model_cnt, e_epc, e_bva, e_vec;
    logic [4:0]  e_code;
    int          w;
    model_cnt = exp_cnt;
    for (int it = 0; it < 800; it++) begin
      m_valid = ($urandom_range(3) != 0); m_stall = ($urandom_range(3) == 0);
      m_pc = $urandom & 32'hFFFFFFFC; m_bd = $urandom_range(1); m_daddr = $urandom;
      m_adel_if = ($urandom_range(15) == 0); m_ri = ($urandom_range(15) == 0);
      m_ov = ($urandom_range(15) == 0); m_sys = ($urandom_range(15) == 0);
      m_bp = ($urandom_range(15) == 0); m_adel_d = ($urandom_range(15) == 0);
      m_ades_d = ($urandom_range(15) == 0); m_eret = ($urandom_range(9) == 0);
      int_req = ($urandom_range(11) == 0); status_bev = $urandom_range(1);
      cp0_epc = $urandom; redir_ready = $urandom_range(1);
      #1;
      if (cap_pend) begin model_rpc = cp0_epc; cap_pend = 0; end
      w = winner();
      take = !model_redir && m_valid && !m_stall && (w >= 0);
      tests++; if (flush !== take) begin fails++; $display("FAIL rnd_flush it=%0d: got %0b want %0b", it, flush, take); end
      if (model_redir) begin
        tests++; if (redir_pc !== model_rpc) begin fails++; $display("FAIL rnd_rpc it=%0d: got %h want %h", it, redir_pc, model_rpc); end
      end
      e_code = (w >= 0) ? CODE[w] : 5'h0;
      e_eret = (w == 8); e_bd = m_bd; e_epc = m_bd ? m_pc - 32'd4 : m_pc;
      e_bva = (w == 1) ? m_pc : ((w == 6 || w == 7) ? m_daddr : 32'h0);
      e_vec = status_bev ? BEV1 : BEV0;
      tick();
      if (inc_pend) model_cnt++;
      inc_pend = 0;
      if (take) begin
        model_redir = 1; inc_pend = !e_eret;
        if (e_eret) cap_pend = 1; else model_rpc = e_vec;
      end else if (model_redir && redir_ready) begin
        model_redir = 0;
      end
      tests++; if (exc_valid !== take || exc_eret !== (take && e_eret) || redir_valid !== model_redir) begin
        fails++; $display("FAIL rnd_ctl it=%0d: valid=%0b eret=%0b redir=%0b want %0b %0b %0b", it, exc_valid, exc_eret, redir_valid, take, take && e_eret, model_redir); end
      tests++; if (exc_cnt !== cnt_ref(model_cnt)) begin
        fails++; $display("FAIL rnd_cnt it=%0d: got %0d want %0d", it, exc_cnt, cnt_ref(model_cnt)); end
      if (take) begin
        tests++; if (exc_bd !== e_bd || exc_epc !== e_epc || exc_badvaddr !== e_bva || (!e_eret && exc_excode !== e_code)) begin
          fails++; $display("FAIL rnd_exc it=%0d: bd=%0b epc=%h bva=%h code=%h want %0b %h %h %h", it, exc_bd, exc_epc, exc_badvaddr, exc_excode, e_bd, e_epc, e_bva, e_code); end
      end
    end
    clr();
  endtask

  initial begin
    test_reset();
    test_ri();
    test_ov_bd();
    test_int_prio();
    test_eret();
    test_redir_hold();
    test_stall_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
